// File: rtl/elevator_request_unit.sv
// Request front-end for the 4-floor elevator: sync + edge-detect calls/keys, pending latch, SCAN target select.
// Latency: input edge -> pending in SYNC_STAGES+1 cycles (+DEBOUNCE_CY with debounce); pending -> target in 1 cycle.
// Backpressure: none; requests are level-latched and can never be lost or stalled.
// Optional build macro: REQ_DEBOUNCE_EN adds a per-input stability-counter debouncer.
module elevator_request_unit #(
  parameter int SYNC_STAGES = 2,   // synchronizer depth, must be >= 2
  parameter int DEBOUNCE_CY = 16   // stable cycles required by the debouncer
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [3:0] call_sw,
  input  logic [3:0] cab_key_n,
  input  logic [1:0] cur_floor,
  input  logic       dir_up,
  input  logic       serve_valid,
  output logic [3:0] pending,
  output logic       target_valid,
  output logic [1:0] target_floor,
  output logic [3:0] req_led
);

  // Idle levels of the raw inputs: call switches rest low, cabin keys rest high.
  localparam logic [7:0] IDLE_LVL = 8'hF0;

  logic [7:0]                  raw_in;
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  sync_act;
  logic [7:0]                  req_lvl;
  logic [7:0]                  prev_q;
  logic [7:0]                  edge_q;
  logic [3:0]                  req_set;
  logic [3:0]                  serve_clr;
  logic [3:0]                  pending_q;
  logic [1:0]                  above_f;
  logic [1:0]                  below_f;
  logic                        above_vld;
  logic                        below_vld;
  logic [1:0]                  sel_floor;

  assign raw_in = {cab_key_n, call_sw};

  // Multi-stage synchronizer; reset loads idle levels so an input held during reset fires on release.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= {SYNC_STAGES{IDLE_LVL}};
    end else begin
      sync_q[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Normalise to active-high: bit set means "switch on" / "key pressed".
  assign sync_act = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

`ifdef REQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CY + 1);

  logic [7:0][CNT_W-1:0] stab_cnt;
  logic [7:0]            deb_q;

  // Debouncer: the accepted level flips only after DEBOUNCE_CY consecutive cycles at the new level.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      stab_cnt <= '0;
      deb_q    <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (sync_act[b] == deb_q[b]) begin
          stab_cnt[b] <= '0;
        end else if (stab_cnt[b] == CNT_W'(DEBOUNCE_CY - 1)) begin
          deb_q[b]    <= sync_act[b];
          stab_cnt[b] <= '0;
        end else begin
          stab_cnt[b] <= stab_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  assign req_lvl = deb_q;
`else
  assign req_lvl = sync_act;
`endif

  // Registered rising-edge detect on the active-high levels; holding an input yields a single pulse.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= req_lvl;
      edge_q <= req_lvl & ~prev_q;
    end
  end

  // Hall call and cabin key for the same floor are merged into one request.
  assign req_set   = edge_q[3:0] | edge_q[7:4];
  assign serve_clr = serve_valid ? (4'b0001 << cur_floor) : 4'b0000;

  // Pending latch: a new request beats a same-cycle serve so a re-press re-opens the door.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~serve_clr) | req_set;
    end
  end

  // SCAN selection: current floor first, then continue in travel direction, else reverse.
  always_comb begin
    above_vld = 1'b0;
    above_f   = cur_floor;
    below_vld = 1'b0;
    below_f   = cur_floor;
    sel_floor = cur_floor;
    // Scan downward so the lowest pending floor above cur_floor is written last.
    for (int f = 3; f >= 0; f--) begin
      if ((f > int'(cur_floor)) && pending_q[f]) begin
        above_vld = 1'b1;
        above_f   = 2'(f);
      end
    end
    // Scan upward so the highest pending floor below cur_floor is written last.
    for (int f = 0; f < 4; f++) begin
      if ((f < int'(cur_floor)) && pending_q[f]) begin
        below_vld = 1'b1;
        below_f   = 2'(f);
      end
    end
    if (pending_q[cur_floor]) begin
      sel_floor = cur_floor;
    end else if (dir_up) begin
      sel_floor = above_vld ? above_f : below_f;
    end else begin
      sel_floor = below_vld ? below_f : above_f;
    end
  end

  // Target register; floor holds its last value while nothing is pending.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      target_valid <= 1'b0;
      target_floor <= 2'd0;
    end else begin
      target_valid <= |pending_q;
      if (|pending_q) begin
        target_floor <= sel_floor;
      end
    end
  end

  assign pending = pending_q;
  assign req_led = pending_q;

endmodule

// File: tb/tb_elevator_request_unit.sv
// Self-checking bench for elevator_request_unit (default build, no debounce).
// Latency: n/a.
// Backpressure: n/a.
module tb_elevator_request_unit;

  logic       CLOCK_50 = 1'b0;
  logic       RST_N;
  logic [3:0] call_sw;
  logic [3:0] cab_key_n;
  logic [1:0] cur_floor;
  logic       dir_up;
  logic       serve_valid;
  logic [3:0] pending;
  logic       target_valid;
  logic [1:0] target_floor;
  logic [3:0] req_led;

  int n_tests = 0;
  int n_fail  = 0;

  elevator_request_unit #(.SYNC_STAGES(2), .DEBOUNCE_CY(16)) dut (
    .CLOCK_50    (CLOCK_50),
    .RST_N       (RST_N),
    .call_sw     (call_sw),
    .cab_key_n   (cab_key_n),
    .cur_floor   (cur_floor),
    .dir_up      (dir_up),
    .serve_valid (serve_valid),
    .pending     (pending),
    .target_valid(target_valid),
    .target_floor(target_floor),
    .req_led     (req_led)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    string      name;
    logic [3:0] call;
    logic [3:0] key_n;
    logic [1:0] cur;
    logic       dir;
    logic       serve;
    int         wait_cy;
    logic [3:0] ep;
    logic       etv;
    logic [1:0] etf;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input string nm, input logic [3:0] c, input logic [3:0] k,
                              input logic [1:0] cf, input logic d, input logic s, input int w,
                              input logic [3:0] ep, input logic etv, input logic [1:0] etf);
    vec_t v;
    v.name = nm; v.call = c; v.key_n = k; v.cur = cf; v.dir = d; v.serve = s;
    v.wait_cy = w; v.ep = ep; v.etv = etv; v.etf = etf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] ep, input logic etv, input logic [1:0] etf);
    chk({nm, ".pending"}, 32'(pending), 32'(ep));
    chk({nm, ".req_led"}, 32'(req_led), 32'(ep));
    chk({nm, ".tvalid"}, 32'(target_valid), 32'(etv));
    chk({nm, ".tfloor"}, 32'(target_floor), 32'(etf));
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  int         sets;
  logic       prev_p1;

  initial begin
    // Directed vectors: one-cycle pulse of inputs, then wait_cy cycles, then compare.
    //            name          call     key_n    cur  dir  srv  w  pending  tv  tf
    vecs[0]  = mk("srv_f2",     4'b0000, 4'b1111, 2'd2, 1'b1, 1'b1, 1, 4'b0000, 1'b0, 2'd2);
    vecs[1]  = mk("key3",       4'b0000, 4'b0111, 2'd2, 1'b1, 1'b0, 4, 4'b1000, 1'b1, 2'd3);
    vecs[2]  = mk("srv_f3",     4'b0000, 4'b1111, 2'd3, 1'b1, 1'b1, 1, 4'b0000, 1'b0, 2'd3);
    vecs[3]  = mk("rev_up",     4'b0001, 4'b1111, 2'd1, 1'b1, 1'b0, 4, 4'b0001, 1'b1, 2'd0);
    vecs[4]  = mk("scan_up",    4'b0000, 4'b0111, 2'd1, 1'b1, 1'b0, 4, 4'b1001, 1'b1, 2'd3);
    vecs[5]  = mk("scan_dn",    4'b0000, 4'b1111, 2'd1, 1'b0, 1'b0, 1, 4'b1001, 1'b1, 2'd0);
    vecs[6]  = mk("near_up",    4'b0100, 4'b1111, 2'd1, 1'b1, 1'b0, 4, 4'b1101, 1'b1, 2'd2);
    vecs[7]  = mk("at_cur",     4'b0000, 4'b1111, 2'd3, 1'b0, 1'b0, 1, 4'b1101, 1'b1, 2'd3);
    vecs[8]  = mk("srv3_dn",    4'b0000, 4'b1111, 2'd3, 1'b0, 1'b1, 1, 4'b0101, 1'b1, 2'd2);
    vecs[9]  = mk("call1_dn",   4'b0010, 4'b1111, 2'd3, 1'b0, 1'b0, 4, 4'b0111, 1'b1, 2'd2);
    vecs[10] = mk("at_f0",      4'b0000, 4'b1111, 2'd0, 1'b1, 1'b0, 1, 4'b0111, 1'b1, 2'd0);
    vecs[11] = mk("srv0",       4'b0000, 4'b1111, 2'd0, 1'b1, 1'b1, 1, 4'b0110, 1'b1, 2'd1);
    vecs[12] = mk("srv1",       4'b0000, 4'b1111, 2'd1, 1'b1, 1'b1, 1, 4'b0100, 1'b1, 2'd2);
    vecs[13] = mk("srv_np",     4'b0000, 4'b1111, 2'd1, 1'b1, 1'b1, 1, 4'b0100, 1'b1, 2'd2);
    vecs[14] = mk("srv2",       4'b0000, 4'b1111, 2'd2, 1'b1, 1'b1, 1, 4'b0000, 1'b0, 2'd2);
    vecs[15] = mk("or_f0",      4'b0001, 4'b1110, 2'd2, 1'b0, 1'b0, 4, 4'b0001, 1'b1, 2'd0);
    vecs[16] = mk("srv0b",      4'b0000, 4'b1111, 2'd0, 1'b0, 1'b1, 1, 4'b0000, 1'b0, 2'd0);

    // Reset with idle inputs.
    RST_N       = 1'b0;
    call_sw     = 4'b0000;
    cab_key_n   = 4'b1111;
    cur_floor   = 2'd0;
    dir_up      = 1'b1;
    serve_valid = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk_out("reset", 4'b0000, 1'b0, 2'd0);
    step();
    RST_N = 1'b1;
    step();
    step();

    // Single-cycle call pulse on floor 2: pending on the 3rd edge after sampling, target one later.
    step();
    call_sw = 4'b0100;
    step();
    call_sw = 4'b0000;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("lat_early.pending", 32'(pending), 32'h0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("lat_exact.pending", 32'(pending), 32'h4);
    chk("lat_exact.tvalid", 32'(target_valid), 32'h0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk_out("lat_target", 4'b0100, 1'b1, 2'd2);

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      step();
      call_sw     = vecs[i].call;
      cab_key_n   = vecs[i].key_n;
      cur_floor   = vecs[i].cur;
      dir_up      = vecs[i].dir;
      serve_valid = vecs[i].serve;
      step();
      call_sw     = 4'b0000;
      cab_key_n   = 4'b1111;
      serve_valid = 1'b0;
      repeat (vecs[i].wait_cy) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      chk_out(vecs[i].name, vecs[i].ep, vecs[i].etv, vecs[i].etf);
    end

    // Simultaneous set and clear at floor 3: set must win.
    step();
    cur_floor = 2'd3;
    dir_up    = 1'b0;
    cab_key_n = 4'b0111;
    step();
    cab_key_n = 4'b1111;
    repeat (4) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("sc_pre.pending", 32'(pending), 32'h8);
    step();
    cab_key_n = 4'b0111;
    step();
    cab_key_n = 4'b1111;
    step();
    step();
    serve_valid = 1'b1;
    step();
    serve_valid = 1'b0;
    @(negedge CLOCK_50);
    chk("sc_setwins.pending", 32'(pending), 32'h8);
    step();
    serve_valid = 1'b1;
    step();
    serve_valid = 1'b0;
    @(negedge CLOCK_50);
    chk("sc_clear.pending", 32'(pending), 32'h0);

    // Held call plus duplicate key on floor 1: one set, one serve clears it for good.
    step();
    cur_floor = 2'd0;
    dir_up    = 1'b1;
    call_sw   = 4'b0010;
    sets      = 0;
    prev_p1   = pending[1];
    for (int c = 0; c < 50; c++) begin
      step();
      if (c == 2)  cab_key_n = 4'b1101;
      if (c == 3)  cab_key_n = 4'b1111;
      if (c == 10) begin cur_floor = 2'd1; serve_valid = 1'b1; end
      if (c == 11) serve_valid = 1'b0;
      @(negedge CLOCK_50);
      if (pending[1] && !prev_p1) sets++;
      prev_p1 = pending[1];
    end
    call_sw = 4'b0000;
    repeat (5) step();
    @(negedge CLOCK_50);
    chk("hold.sets", 32'(sets), 32'd1);
    chk("hold.pending", 32'(pending), 32'h0);
    chk("hold.tvalid", 32'(target_valid), 32'h0);

    // Mid-operation asynchronous reset, with a call held through reset.
    step();
    cur_floor = 2'd0;
    dir_up    = 1'b1;
    call_sw   = 4'b0100;
    step();
    call_sw = 4'b0000;
    repeat (5) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk_out("pre_rst", 4'b0100, 1'b1, 2'd2);
    @(posedge CLOCK_50);
    #7;
    call_sw = 4'b1000;
    RST_N   = 1'b0;
    #2;
    chk_out("async_rst", 4'b0000, 1'b0, 2'd0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    RST_N = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk_out("held_thru_rst", 4'b1000, 1'b1, 2'd3);
    call_sw = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
